// File: rtl/dmem_store_buffer_if.sv
// MEM-stage data port and data-memory port of the store buffer.
// Default build has store coalescing disabled (see STB_COALESCE_EN).
interface dmem_store_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_memwrite;
    logic              cpu_memread;
    logic [DATA_W-1:0] cpu_rdata;
    logic              stall;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              empty;
    logic [CW-1:0]     count;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_memwrite, cpu_memread,
        input  mem_rdata, mem_ready,
        output cpu_rdata, stall, mem_addr, mem_wdata, mem_wen,
        output empty, count
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_memwrite, cpu_memread,
        output mem_rdata, mem_ready,
        input  cpu_rdata, stall, mem_addr, mem_wdata, mem_wen,
        input  empty, count
    );
endinterface

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer with youngest-match load forwarding.
// Optional macro STB_COALESCE_EN merges stores into the youngest entry.
module dmem_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    dmem_store_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    logic              w_full;
    logic              w_drain;
    logic              w_accept;
    logic              w_alloc;
    logic              w_coal;
    logic [PW-1:0]     w_last;
    logic              w_hit;
    logic [DATA_W-1:0] w_fdata;
    logic [PW-1:0]     w_idx;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_drain = (r_count != '0) && !bus.cpu_memread && bus.mem_ready;
    assign w_last  = r_tail - PW'(1);

`ifdef STB_COALESCE_EN
    // A store hitting the youngest entry merges, unless that entry leaves now.
    assign w_coal = bus.cpu_memwrite && r_valid[w_last]
                 && (r_addr[w_last][ADDR_W-1:2] == bus.cpu_addr[ADDR_W-1:2])
                 && !(w_drain && (r_count == CW'(1)));
`else
    assign w_coal = 1'b0;
`endif

    assign w_accept = bus.cpu_memwrite && (!w_full || w_drain || w_coal);
    assign w_alloc  = w_accept && !w_coal;

    assign bus.stall     = bus.cpu_memwrite && !w_accept;
    assign bus.mem_wen   = w_drain;
    assign bus.mem_addr  = w_drain ? r_addr[r_head] : bus.cpu_addr;
    assign bus.mem_wdata = r_data[r_head];
    assign bus.empty     = (r_count == '0);
    assign bus.count     = r_count;
    assign bus.cpu_rdata = (bus.cpu_memread && w_hit) ? w_fdata
                                                      : bus.mem_rdata;

    // Walk entries oldest to youngest so the last match wins.
    always_comb begin
        w_hit   = 1'b0;
        w_fdata = '0;
        w_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if (r_valid[w_idx] &&
                (r_addr[w_idx][ADDR_W-1:2] == bus.cpu_addr[ADDR_W-1:2])) begin
                w_hit   = 1'b1;
                w_fdata = r_data[w_idx];
            end
        end
    end

    // Pointer, occupancy and valid-bit bookkeeping; reset drops all stores.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_drain) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PW'(1);
            end
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PW'(1);
            end
            unique case ({w_alloc, w_drain})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload; qualified by r_valid so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_addr[r_tail] <= bus.cpu_addr;
            r_data[r_tail] <= bus.cpu_wdata;
        end
        if (w_coal) begin
            r_data[w_last] <= bus.cpu_wdata;
        end
    end
endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Posted-write buffer between the pipeline's MEM-stage data port and the data memory model.
- CPU stores retire in one cycle into a small FIFO. The FIFO drains to memory whenever the data port is not being used by a load.
- Loads read memory directly, with youngest-match forwarding from pending buffered stores.
- Sits between Top's alu_DMEM/writedata_DMEM/memwrite_MEM/readdata_MEM and the datamem instance.

Parameters:
- DEPTH, 4, number of store entries; must be a power of 2, minimum 2.
- DATA_W, 32, store data width.
- ADDR_W, 32, byte address width; entry match uses address bits [ADDR_W-1:2] (word granularity).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- cpu_addr  input  ADDR_W  MEM-stage byte address (alu_DMEM).
- cpu_wdata  input  DATA_W  store data (writedata_DMEM).
- cpu_memwrite  input  1  store request this cycle.
- cpu_memread  input  1  load request this cycle; never high in the same cycle as cpu_memwrite.
- cpu_rdata  output  DATA_W  load data to CPU (readdata_MEM).
- stall  output  1  store not accepted; CPU must hold MEM stage.
- mem_addr  output  ADDR_W  address to data memory.
- mem_wdata  output  DATA_W  write data to data memory.
- mem_wen  output  1  memory write enable; memory writes at posedge.
- mem_rdata  input  DATA_W  combinational read data from memory.
- mem_ready  input  1  memory can accept a write this cycle; tie to 1 for the single-cycle model.
- empty  output  1  no pending stores.
- count  output  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset (rst=0, async): head=0, tail=0, count=0, all valid bits cleared.
  - Outputs under reset: mem_wen=0, stall=0, empty=1.
  - Pending stores are discarded, including on reset mid-drain.
- Storage: circular FIFO of {addr, data}. head = oldest entry, tail = next free slot. Pointers wrap modulo DEPTH.
- full = (count==DEPTH).
- drain_fire = (count!=0) && !cpu_memread && mem_ready, computed combinationally.
  - mem_wen = drain_fire.
  - mem_addr = drain_fire ? head.addr : cpu_addr.
  - mem_wdata = head.data.
  - On posedge with drain_fire: head advances by 1.
- Enqueue: accept = cpu_memwrite && (!full || drain_fire).
  - On posedge with accept: entry[tail] <= {cpu_addr, cpu_wdata}; tail advances by 1.
- stall = cpu_memwrite && !accept. This is combinational, zero-latency.
- count update:
  - +1 on accept only.
  - -1 on drain_fire only.
  - Unchanged when both occur; a full buffer with both occurring stays full and deasserts stall.
- Loads (cpu_memread=1): no drain that cycle.
  - cpu_rdata = data of the youngest valid entry whose addr[ADDR_W-1:2] == cpu_addr[ADDR_W-1:2].
  - Otherwise cpu_rdata = mem_rdata.
  - Loads never stall.
- cpu_rdata when cpu_memread=0 equals mem_rdata (don't-care to CPU).
- Store latency to memory: earliest write is in the cycle after acceptance. Memory order is strictly FIFO.
- mem_ready=0: buffer holds; stores accumulate until full, then stall.
- empty = (count==0).

Optional Feature:
- Macro: STB_COALESCE_EN.
- Defined:
  - Condition: a store whose word address matches the youngest valid entry (tail-1), and that entry is not the one draining this cycle (not the head with drain_fire, when count==1).
  - Action: the store overwrites that entry's data in place. tail and count are unchanged, and accept is asserted even when full.
- Undefined: every accepted store allocates a new entry.

Test Plan:
- Reset mid-drain: rst=0 with count=3 -> count=0, empty=1, mem_wen=0 immediately (asynchronous). No further writes after release.
- Store/drain: single store addr 0x10 data 0x5 with cpu_memread=0 afterwards -> next cycle mem_wen=1, mem_addr=0x10, mem_wdata=0x5; count returns to 0.
- Full and stall:
  - Setup: mem_ready=0; 5 consecutive stores to 0x0,0x4,0x8,0xC,0x10.
  - First four: accepted, count=4.
  - Fifth: stall=1. Raising mem_ready with the fifth still asserted -> accepted that cycle, stall=0, count stays 4.
- Forwarding: stores 0x20<-0xA then 0x20<-0xB (mem_ready=0), then load 0x22 -> cpu_rdata=0xB. Load 0x24 -> cpu_rdata=mem_rdata.
- Load priority: count=2, load to 0x40 -> mem_wen=0, mem_addr=0x40. Drain resumes on the next non-load cycle, in FIFO order.
- Coalescing: two back-to-back stores to 0x30 (0x1, then 0x2) with mem_ready=0.
  - With STB_COALESCE_EN: count=1, drained data=0x2.
  - Without: count=2, memory receives 0x1 then 0x2.
